reg_file_2r1w: RTL and testbench

//  Parametrised 2-read/1-write register file for the SDSU bus datapath.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_read_port.sv | 69 ++++++
 rtl/reg_file_2r1w.sv | 155 +++++++++++++++
 tb/tb_reg_file_2r1w.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizes for the 2R1W register file
//
// Contents:
//   rf_state_e  - sweep FSM states: INIT (zeroing sweep running), IDLE (normal access)
//   RF_DATA_W   - default data width
//   RF_DEPTH    - default number of entries
package reg_file_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one registered read port with range check, zero register and write bypass
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           read strobe, already qualified by the top (IDLE and no clear)
//   addr         read address
//   wr_en        write strobe, already qualified by the top
//   wr_addr      write address, compared against addr for the write-first bypass
//   wr_data      write data, returned on a bypass hit
//   mem_data     array contents at addr
//   data         registered read data, holds its value when no read occurs
//   valid        1-cycle pulse: data is valid
//   err          1-cycle pulse alongside valid: addr was out of range
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err
);

    // One extra bit so a DEPTH equal to 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic              out_of_range;
    logic [DATA_W-1:0] value;

    assign out_of_range = ({1'b0, addr} >= LIMIT);

    // Ordered checks: range error, hardwired zero, same-cycle write, array.
    always_comb begin
        value = mem_data;
        if (out_of_range) begin
            value = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if (wr_en && (wr_addr == addr)) begin
            value = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= en;
            err   <= en && out_of_range;
            if (en) begin
                data <= value;
            end
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - parametrised 2-read/1-write register file with zeroing sweep
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   clear                        1-cycle pulse: restart the zeroing sweep
//   busy                         1 while the sweep runs; all accesses are ignored
//   wr_en, wr_addr, wr_data      write port
//   rd0_en, rd0_addr             read port 0 request
//   rd0_data, rd0_valid, rd0_err read port 0 registered response
//   rd1_en, rd1_addr             read port 1 request
//   rd1_data, rd1_valid, rd1_err read port 1 registered response
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    output logic              rd0_err,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    output logic              rd1_err
);

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_nxt;
    logic              sweep_we;

    logic              access_ok;
    logic              wr_qual;
    logic              wr_in_range;
    logic              wr_is_zero;
    logic              wr_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd0_mem;
    logic [DATA_W-1:0] rd1_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        sweep_we      = 1'b0;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                if (clear) begin
                    sweep_cnt_nxt = '0;
                end else if (sweep_cnt == LAST) begin
                    state_nxt     = IDLE;
                    sweep_cnt_nxt = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear) begin
                    state_nxt     = INIT;
                    sweep_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt     = INIT;
                sweep_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state == INIT);

    // A clear arriving in IDLE pre-empts any access in the same cycle.
    assign access_ok   = (state == IDLE) && !clear;
    assign wr_qual     = access_ok && wr_en;
    assign wr_in_range = ({1'b0, wr_addr} < LIMIT);
    assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok       = wr_qual && wr_in_range && !wr_is_zero;

    // No reset on the array: the sweep is the only thing that defines it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range addresses are masked to zero inside the read port.
    assign rd0_mem = mem[rd0_addr];
    assign rd1_mem = mem[rd1_addr];

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (access_ok && rd0_en),
        .addr     (rd0_addr),
        .wr_en    (wr_qual),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mem_data (rd0_mem),
        .data     (rd0_data),
        .valid    (rd0_valid),
        .err      (rd0_err)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (access_ok && rd1_en),
        .addr     (rd1_addr),
        .wr_en    (wr_qual),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mem_data (rd1_mem),
        .data     (rd1_data),
        .valid    (rd1_valid),
        .err      (rd1_err)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - directed bench for reg_file_2r1w at DEPTH=32 and DEPTH=20
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        clear, busy, wr_en;
    logic [4:0]  wr_addr, rd0_addr, rd1_addr;
    logic [31:0] wr_data, rd0_data, rd1_data;
    logic        rd0_en, rd0_valid, rd0_err, rd1_en, rd1_valid, rd1_err;

    logic        clear_b, busy_b, wr_en_b;
    logic [4:0]  wr_addr_b, rd0_addr_b, rd1_addr_b;
    logic [31:0] wr_data_b, rd0_data_b, rd1_data_b;
    logic        rd0_en_b, rd0_valid_b, rd0_err_b, rd1_en_b, rd1_valid_b, rd1_err_b;

    int errors = 0;
    int checks = 0;

    reg_file_2r1w #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .rd0_valid(rd0_valid), .rd0_err(rd0_err),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .rd1_valid(rd1_valid), .rd1_err(rd1_err)
    );

    reg_file_2r1w #(.DATA_W(32), .DEPTH(20), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .busy(busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd0_en(rd0_en_b), .rd0_addr(rd0_addr_b), .rd0_data(rd0_data_b),
        .rd0_valid(rd0_valid_b), .rd0_err(rd0_err_b),
        .rd1_en(rd1_en_b), .rd1_addr(rd1_addr_b), .rd1_data(rd1_data_b),
        .rd1_valid(rd1_valid_b), .rd1_err(rd1_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd0_en = 0; rd0_addr = 0; rd1_en = 0; rd1_addr = 0;
        clear_b = 0; wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0;
        rd0_en_b = 0; rd0_addr_b = 0; rd1_en_b = 0; rd1_addr_b = 0;
    endtask

    task automatic test_reset();
        int n, na, nb, bad;
        rst_n = 0;
        idle_inputs();
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        checks++; if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b exp 00", rd0_valid, rd1_valid); end
        checks++; if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h exp 0", rd0_data, rd1_data); end
        checks++; if (rd0_err !== 1'b0 || rd1_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", rd0_err, rd1_err); end
        rst_n = 1;
        n = 0; na = 0; nb = 0;
        while ((busy === 1'b1 || busy_b === 1'b1) && n < 100) begin
            if (busy === 1'b1) na++;
            if (busy_b === 1'b1) nb++;
            tick();
            n++;
        end
        checks++; if (na != 32) begin errors++; $display("FAIL reset_sweep_len got %0d exp 32", na); end
        checks++; if (nb != 20) begin errors++; $display("FAIL reset_sweep_len_d20 got %0d exp 20", nb); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            rd0_en = 1; rd0_addr = 5'(i);
            rd1_en = 1; rd1_addr = 5'(31 - i);
            tick();
            rd0_en = 0; rd1_en = 0;
            if (rd0_data !== 32'h0 || rd1_data !== 32'h0 || rd0_valid !== 1'b1 || rd1_valid !== 1'b1) bad++;
            tick();
            if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL post_sweep_reads got %0d bad exp 0", bad); end
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0;
        rd0_en = 1; rd0_addr = 5;
        tick();
        rd0_en = 0;
        checks++; if (rd0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h exp deadbeef", rd0_data); end
        checks++; if (rd0_valid !== 1'b1 || rd0_err !== 1'b0) begin errors++; $display("FAIL wr_rd_valid got v=%b e=%b exp v=1 e=0", rd0_valid, rd0_err); end
        tick();
        checks++; if (rd0_valid !== 1'b0 || rd0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got v=%b d=%h exp v=0 d=deadbeef", rd0_valid, rd0_data); end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
        rd0_en = 1; rd0_addr = 7;
        rd1_en = 1; rd1_addr = 7;
        tick();
        wr_en = 0;
        checks++; if (rd0_data !== 32'h12345678 || rd1_data !== 32'h12345678) begin errors++; $display("FAIL bypass got %h %h exp 12345678", rd0_data, rd1_data); end
        checks++; if (rd0_valid !== 1'b1 || rd1_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b%b exp 11", rd0_valid, rd1_valid); end
        rd0_addr = 5;
        tick();
        rd0_en = 0; rd1_en = 0;
        checks++; if (rd1_data !== 32'h12345678 || rd0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_after_bypass got %h %h exp deadbeef 12345678", rd0_data, rd1_data); end
    endtask

    task automatic test_zero_range();
        int bad;
        logic [31:0] exp;
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 0;
        rd0_en = 1; rd0_addr = 0;
        tick();
        rd0_en = 0;
        checks++; if (rd0_data !== 32'h0 || rd0_err !== 1'b0 || rd0_valid !== 1'b1) begin errors++; $display("FAIL zero_reg got d=%h e=%b v=%b exp d=0 e=0 v=1", rd0_data, rd0_err, rd0_valid); end

        wr_en_b = 1; wr_addr_b = 19; wr_data_b = 32'h19191919;
        tick();
        wr_addr_b = 25; wr_data_b = 32'hBADBAD00;
        tick();
        wr_en_b = 0;
        rd0_en_b = 1; rd0_addr_b = 25;
        rd1_en_b = 1; rd1_addr_b = 19;
        tick();
        checks++; if (rd0_data_b !== 32'h0 || rd0_err_b !== 1'b1 || rd0_valid_b !== 1'b1) begin errors++; $display("FAIL range_rd25 got d=%h e=%b v=%b exp d=0 e=1 v=1", rd0_data_b, rd0_err_b, rd0_valid_b); end
        checks++; if (rd1_data_b !== 32'h19191919 || rd1_err_b !== 1'b0) begin errors++; $display("FAIL range_rd19 got d=%h e=%b exp d=19191919 e=0", rd1_data_b, rd1_err_b); end
        rd0_addr_b = 20; rd1_addr_b = 31;
        tick();
        rd0_en_b = 0; rd1_en_b = 0;
        checks++; if (rd0_err_b !== 1'b1 || rd1_err_b !== 1'b1 || rd0_data_b !== 32'h0) begin errors++; $display("FAIL range_boundary got e=%b%b d=%h exp e=11 d=0", rd0_err_b, rd1_err_b, rd0_data_b); end
        tick();
        checks++; if (rd0_err_b !== 1'b0 || rd0_valid_b !== 1'b0) begin errors++; $display("FAIL err_pulse got e=%b v=%b exp e=0 v=0", rd0_err_b, rd0_valid_b); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            exp = (i == 19) ? 32'h19191919 : 32'h0;
            rd0_en_b = 1; rd0_addr_b = 5'(i);
            tick();
            if (rd0_data_b !== exp || rd0_err_b !== 1'b0) bad++;
        end
        rd0_en_b = 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL range_write_dropped got %0d bad exp 0", bad); end
    endtask

    task automatic test_clear();
        int n, vbad;
        wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 0;
        rd0_en = 1; rd0_addr = 3;
        tick();
        checks++; if (rd0_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL clear_pre got %h exp a5a5a5a5", rd0_data); end
        clear = 1;
        tick();
        clear = 0; rd0_en = 0;
        checks++; if (busy !== 1'b1 || rd0_valid !== 1'b0) begin errors++; $display("FAIL clear_wins got busy=%b v=%b exp busy=1 v=0", busy, rd0_valid); end
        repeat (4) tick();
        clear = 1;
        tick();
        clear = 0;
        n = 0; vbad = 0;
        while (busy === 1'b1 && n < 100) begin
            rd0_en = 1; rd0_addr = 3;
            rd1_en = 1; rd1_addr = 3;
            wr_en = 1; wr_addr = 3; wr_data = 32'h55555555;
            tick();
            n++;
            if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) vbad++;
        end
        wr_en = 0;
        checks++; if (n != 32) begin errors++; $display("FAIL clear_restart_len got %0d exp 32", n); end
        checks++; if (vbad != 0) begin errors++; $display("FAIL busy_valid got %0d pulses exp 0", vbad); end
        tick();
        rd0_en = 0; rd1_en = 0;
        checks++; if (rd0_data !== 32'h0 || rd1_data !== 32'h0 || rd0_valid !== 1'b1) begin errors++; $display("FAIL clear_zeroed got %h %h v=%b exp 0 0 v=1", rd0_data, rd1_data, rd0_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0;
        rd0_en = 1; rd0_addr = 5;
        tick();
        rd0_en = 0;
        checks++; if (rd0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_pre got %h exp deadbeef", rd0_data); end
        clear = 1;
        tick();
        clear = 0;
        repeat (10) tick();
        rst_n = 0;
        #1;
        checks++; if (rd0_data !== 32'h0 || rd0_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_async got d=%h v=%b busy=%b exp d=0 v=0 busy=1", rd0_data, rd0_valid, busy); end
        tick();
        tick();
        rst_n = 1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL mid_sweep_len got %0d exp 32", n); end
        rd0_en = 1; rd0_addr = 5;
        tick();
        rd0_en = 0;
        checks++; if (rd0_data !== 32'h0 || rd0_valid !== 1'b1) begin errors++; $display("FAIL mid_zeroed got %h v=%b exp 0 v=1", rd0_data, rd0_valid); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_range();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
